sbox_share_sched: RTL and testbench
===================================

# sbox_share_sched

Scheduler that time-shares one 32-bit bank of four `s_box` lanes between two requesters in the AES core.
- **Round datapath:** SubBytes on a 128-bit state, four lane passes.
- **Key expansion:** SubWord on a 32-bit word, one lane pass.

Each requester has a valid/ready request channel and a valid/ready response channel. Arbitration is per pass cycle, so a key request can interleave between block words.

## Interface
- `KEY_FIRST`, default 1, selects which requester wins the first contested pass after reset: 1 = key, 0 = block.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `blk_req_valid`  in  1  block request valid
- `blk_req_ready`  out  1  block request can be accepted
- `blk_req_data`  in  128  state; byte 0 = [127:120]
- `blk_rsp_valid`  out  1  SubBytes result valid
- `blk_rsp_ready`  in  1  block response consumed
- `blk_rsp_data`  out  128  SubBytes result, same byte order as `blk_req_data`
- `key_req_valid`  in  1  key request valid
- `key_req_ready`  out  1  key request can be accepted
- `key_req_data`  in  32  word; byte 0 = [31:24]
- `key_rsp_valid`  out  1  SubWord result valid
- `key_rsp_ready`  in  1  key response consumed
- `key_rsp_data`  out  32  SubWord result
- `busy`  out  1  any job in K_PEND or B_RUN

## Operation
- **Transfers:** a transfer occurs on `valid & ready` at a rising edge. Request data is captured into a holding register; the requester need not hold it afterwards.
- **Block FSM:**
  - B_IDLE → B_RUN on accept, word counter `wc`=0.
  - B_RUN: each granted pass substitutes word `wc` (bits [127-32·wc -: 32]) and writes the result into the same slice of `blk_rsp_data`.
  - `wc` increments per granted pass. The grant at `wc`=3 moves the FSM to B_DONE.
  - B_DONE → B_IDLE on `blk_rsp_ready`.
- **Key FSM:**
  - K_IDLE → K_PEND on accept.
  - A granted pass writes `key_rsp_data` and moves the FSM to K_DONE.
  - K_DONE → K_IDLE on `key_rsp_ready`.
- **Ready:** `*_req_ready` = IDLE, or (DONE & `*_rsp_ready`). A response and a new request can therefore transfer on the same edge, giving back-to-back jobs. `*_rsp_valid` = DONE.
- **Arbitration (per cycle):**
  - Only K_PEND requesting: key wins.
  - Only B_RUN requesting: block wins.
  - Both requesting: the `turn` bit decides. `turn` toggles after every contested grant and is initialised from `KEY_FIRST`.
- **Lane usage:** lanes are combinational. The lane input is muxed from the winner's holding register, and the output is registered at the end of the grant cycle. With no winner, lanes idle and no register changes.
- **Data behaviour:**
  - `blk_rsp_data` holds its value between jobs. Its word slices update progressively during B_RUN.
  - Neither data output is qualified except by its valid.
- **Reset** (asynchronous, any time, including mid-job): both FSMs go to IDLE, `wc`=0, and `turn`=`KEY_FIRST`. The in-flight job is discarded with no response.

## Timing
- **Reset values:** `blk_req_ready`=1, `key_req_ready`=1, `blk_rsp_valid`=0, `key_rsp_valid`=0, `blk_rsp_data`=0, `key_rsp_data`=0, `busy`=0.
- **Uncontended key:** accept at edge E0, pass in cycle E0→E1, `key_rsp_valid`=1 after E1. Latency is 1 cycle.
- **Uncontended block:** 4 passes, `blk_rsp_valid`=1 after E4. Latency is 4 cycles.
- **Contended block:** each key pass that wins a contested cycle adds exactly 1 cycle to block latency. Alternation bounds block latency to 8 cycles under continuous key requests.
- **Backpressure:** a response held by a low `*_rsp_ready` stalls only its own channel; the other channel proceeds.

## Configuration
- **`SBOX_SHARE_STATS_EN`**
  - Defined: adds output `stall_cnt` (16 bit, reset 0), a saturating count of cycles in which B_RUN was denied a pass because key won. It saturates at 16'hFFFF.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- **Package `sbox_share_pkg`:** block and key FSM state typedefs, `WORD_W`=32, `LANES`=4, `BLK_WORDS`=4.
- **Sub-module `sbox_word`:** four existing `s_box` instances mapping 32 → 32 bits, byte-aligned, instantiated once.

## Test plan
- **Reset:** assert `rst_n`=0 mid-block-job → all outputs at reset values; after release, `blk_req_ready`=1 and no stale `blk_rsp_valid`.
- **Key alone:** `key_req_data`=32'hcf4f3c09 → `key_rsp_data`=32'h8a84eb01, valid 1 cycle after accept.
- **Block alone:** `blk_req_data`=128'h193de3bea0f4e22b9ac68d2ae9f84808 → `blk_rsp_data`=128'hd42711aee0bf98f1b8b45de51e415230, valid 4 cycles after accept.
- **Contention:** issue the above block request, then the key request 1 cycle later with `KEY_FIRST`=1 → both results correct, block latency 5, key latency 1; with `SBOX_SHARE_STATS_EN`, `stall_cnt`=1.
- **Backpressure and back-to-back:**
  - Hold `key_rsp_ready`=0 for 10 cycles while a block job runs → the block completes in 4 cycles and `key_rsp_data` stays stable.
  - Then send a new request on the same edge as the response → it is accepted that edge.
- **Byte sweep:** 64 block jobs covering bytes 00..ff → every byte matches the AES S-box table, e.g. 00→63, 01→7c, 53→ed, ff→16.

Source files
------------

// File: rtl/sbox_share_pkg.sv
// Shared types and constants for the S-box share scheduler.
package sbox_share_pkg;

    localparam int WORD_W    = 32;
    localparam int LANES     = 4;
    localparam int BLK_WORDS = 4;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_RUN  = 2'd1,
        B_DONE = 2'd2
    } blk_state_e;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_PEND = 2'd1,
        K_DONE = 2'd2
    } key_state_e;

    // Word idx of a 128-bit state; word 0 is the most significant.
    function automatic logic [WORD_W-1:0] get_word(input logic [BLK_WORDS*WORD_W-1:0] s,
                                                   input logic [1:0] idx);
        case (idx)
            2'd0:    return s[127:96];
            2'd1:    return s[95:64];
            2'd2:    return s[63:32];
            default: return s[31:0];
        endcase
    endfunction

    // Replace word idx of a 128-bit state.
    function automatic logic [BLK_WORDS*WORD_W-1:0] put_word(input logic [BLK_WORDS*WORD_W-1:0] s,
                                                             input logic [1:0] idx,
                                                             input logic [WORD_W-1:0] w);
        logic [BLK_WORDS*WORD_W-1:0] r;
        r = s;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/s_box.sv
// AES forward S-box, one byte, purely combinational table lookup.
module s_box (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Entry 0 sits in the top byte of the table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bit offset (255-b)*8.
    assign data_o = SBOX_TBL[{~data_i, 3'b000} +: 8];

endmodule

// File: rtl/sbox_word.sv
// Four byte-aligned S-box lanes forming one 32-bit substitution bank.
module sbox_word
    import sbox_share_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        s_box u_s_box (
            .data_i (word_i[g*8 +: 8]),
            .data_o (word_o[g*8 +: 8])
        );
    end

endmodule

// File: rtl/sbox_share_sched.sv
// Time-shares one sbox_word bank between the block (SubBytes) and key
// (SubWord) requesters with per-cycle round-robin on contention.
// Optional: define SBOX_SHARE_STATS_EN to add the stall_cnt output.
//
// state  | meaning
// B_IDLE | no block job, ready for a request
// B_RUN  | block job holds word wc_q still to substitute
// B_DONE | block result presented, waiting for blk_rsp_ready
// K_IDLE | no key job, ready for a request
// K_PEND | key word waiting for a lane pass
// K_DONE | key result presented, waiting for key_rsp_ready
module sbox_share_sched
    import sbox_share_pkg::*;
#(
    parameter int KEY_FIRST = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        blk_req_valid,
    output logic                        blk_req_ready,
    input  logic [BLK_WORDS*WORD_W-1:0] blk_req_data,
    output logic                        blk_rsp_valid,
    input  logic                        blk_rsp_ready,
    output logic [BLK_WORDS*WORD_W-1:0] blk_rsp_data,
    input  logic                        key_req_valid,
    output logic                        key_req_ready,
    input  logic [WORD_W-1:0]           key_req_data,
    output logic                        key_rsp_valid,
    input  logic                        key_rsp_ready,
    output logic [WORD_W-1:0]           key_rsp_data,
`ifdef SBOX_SHARE_STATS_EN
    output logic                        busy,
    output logic [15:0]                 stall_cnt
`else
    output logic                        busy
`endif
);

    blk_state_e                  blk_st_q, blk_st_d;
    key_state_e                  key_st_q, key_st_d;
    logic [1:0]                  wc_q, wc_d;
    logic                        turn_q, turn_d;   // 1: key wins next contested pass
    logic [BLK_WORDS*WORD_W-1:0] blk_hold_q, blk_rsp_q, blk_rsp_d;
    logic [WORD_W-1:0]           key_hold_q, key_rsp_q, key_rsp_d;
    logic [WORD_W-1:0]           lane_in, lane_out;
    logic                        blk_want, key_want, contested, key_win, blk_win;
    logic                        blk_acc, key_acc;

    assign blk_want  = (blk_st_q == B_RUN);
    assign key_want  = (key_st_q == K_PEND);
    assign contested = blk_want & key_want;
    assign key_win   = key_want & (~blk_want | turn_q);
    assign blk_win   = blk_want & (~key_want | ~turn_q);

    assign blk_req_ready = (blk_st_q == B_IDLE) | ((blk_st_q == B_DONE) & blk_rsp_ready);
    assign key_req_ready = (key_st_q == K_IDLE) | ((key_st_q == K_DONE) & key_rsp_ready);
    assign blk_acc       = blk_req_valid & blk_req_ready;
    assign key_acc       = key_req_valid & key_req_ready;

    assign blk_rsp_valid = (blk_st_q == B_DONE);
    assign key_rsp_valid = (key_st_q == K_DONE);
    assign blk_rsp_data  = blk_rsp_q;
    assign key_rsp_data  = key_rsp_q;
    assign busy          = blk_want | key_want;

    assign lane_in = key_win ? key_hold_q : get_word(blk_hold_q, wc_q);

    sbox_word u_sbox_word (
        .word_i (lane_in),
        .word_o (lane_out)
    );

    // Next-state for both job FSMs, arbitration turn and result registers.
    always_comb begin
        blk_st_d  = blk_st_q;
        key_st_d  = key_st_q;
        wc_d      = wc_q;
        turn_d    = turn_q;
        blk_rsp_d = blk_rsp_q;
        key_rsp_d = key_rsp_q;

        if (contested) turn_d = ~turn_q;

        case (blk_st_q)
            B_IDLE: if (blk_acc) begin
                blk_st_d = B_RUN;
                wc_d     = 2'd0;
            end
            B_RUN: if (blk_win) begin
                blk_rsp_d = put_word(blk_rsp_q, wc_q, lane_out);
                wc_d      = wc_q + 2'd1;
                if (wc_q == 2'(BLK_WORDS - 1)) blk_st_d = B_DONE;
            end
            B_DONE: if (blk_rsp_ready) begin
                blk_st_d = blk_acc ? B_RUN : B_IDLE;
                wc_d     = 2'd0;
            end
            default: blk_st_d = B_IDLE;
        endcase

        case (key_st_q)
            K_IDLE: if (key_acc) key_st_d = K_PEND;
            K_PEND: if (key_win) begin
                key_rsp_d = lane_out;
                key_st_d  = K_DONE;
            end
            K_DONE: if (key_rsp_ready) key_st_d = key_acc ? K_PEND : K_IDLE;
            default: key_st_d = K_IDLE;
        endcase
    end

    // State, result and request holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_st_q   <= B_IDLE;
            key_st_q   <= K_IDLE;
            wc_q       <= 2'd0;
            turn_q     <= (KEY_FIRST != 0);
            blk_rsp_q  <= '0;
            key_rsp_q  <= '0;
            blk_hold_q <= '0;
            key_hold_q <= '0;
        end else begin
            blk_st_q  <= blk_st_d;
            key_st_q  <= key_st_d;
            wc_q      <= wc_d;
            turn_q    <= turn_d;
            blk_rsp_q <= blk_rsp_d;
            key_rsp_q <= key_rsp_d;
            if (blk_acc) blk_hold_q <= blk_req_data;
            if (key_acc) key_hold_q <= key_req_data;
        end
    end

`ifdef SBOX_SHARE_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles where a running block lost the lane to key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         stall_cnt_q <= 16'd0;
        else if (blk_want && key_win && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sbox_share_sched.sv
// Scoreboard bench for sbox_share_sched: drivers push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_sbox_share_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_req_valid, blk_req_ready, blk_rsp_valid, blk_rsp_ready;
    logic [127:0] blk_req_data, blk_rsp_data;
    logic         key_req_valid, key_req_ready, key_rsp_valid, key_rsp_ready;
    logic [31:0]  key_req_data, key_rsp_data;
    logic         busy;
`ifdef SBOX_SHARE_STATS_EN
    logic [15:0]  stall_cnt;
`endif

    sbox_share_sched #(.KEY_FIRST(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .blk_req_valid (blk_req_valid),
        .blk_req_ready (blk_req_ready),
        .blk_req_data  (blk_req_data),
        .blk_rsp_valid (blk_rsp_valid),
        .blk_rsp_ready (blk_rsp_ready),
        .blk_rsp_data  (blk_rsp_data),
        .key_req_valid (key_req_valid),
        .key_req_ready (key_req_ready),
        .key_req_data  (key_req_data),
        .key_rsp_valid (key_rsp_valid),
        .key_rsp_ready (key_rsp_ready),
        .key_rsp_data  (key_rsp_data),
`ifdef SBOX_SHARE_STATS_EN
        .busy          (busy),
        .stall_cnt     (stall_cnt)
`else
        .busy          (busy)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] data;
        int           acc;
        int           lat;
    } exp_t;

    exp_t blk_q[$];
    exp_t key_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent S-box model: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_ref(s[i*8 +: 8]);
        return r;
    endfunction

    // Drivers: called just after a rising edge; return edges waited (1 = accepted at first edge).
    task automatic blk_send(input logic [127:0] d, input logic [127:0] exp, input int lat, output int tries);
        logic r;
        bit   got = 0;
        exp_t e;
        tries = 0;
        blk_req_valid = 1'b1;
        blk_req_data  = d;
        while (!got && tries < 100) begin
            @(negedge clk);
            r = blk_req_ready;
            @(posedge clk);
            tries++;
            if (r) got = 1;
        end
        #1;
        blk_req_valid = 1'b0;
        blk_req_data  = ~d;
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL blk_accept_timeout: got no accept expected accept");
        end else begin
            e.data = exp; e.acc = cyc; e.lat = lat;
            blk_q.push_back(e);
        end
    endtask

    task automatic key_send(input logic [31:0] d, input logic [31:0] exp, input int lat, output int tries);
        logic r;
        bit   got = 0;
        exp_t e;
        tries = 0;
        key_req_valid = 1'b1;
        key_req_data  = d;
        while (!got && tries < 100) begin
            @(negedge clk);
            r = key_req_ready;
            @(posedge clk);
            tries++;
            if (r) got = 1;
        end
        #1;
        key_req_valid = 1'b0;
        key_req_data  = ~d;
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL key_accept_timeout: got no accept expected accept");
        end else begin
            e.data = {96'd0, exp}; e.acc = cyc; e.lat = lat;
            key_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((blk_q.size() != 0 || key_q.size() != 0) && i < 300) begin
            @(posedge clk);
            i++;
        end
        if (i >= 300) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", blk_q.size(), key_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor state.
    logic        kv_prev = 0, khs_prev = 0, bv_prev = 0, bhs_prev = 0;
    logic [31:0] kdata_prev;
    int          kfirst, bfirst;

    always @(negedge clk) begin
        exp_t e;
        logic khs, bhs;
        if (!rst_n) begin
            kv_prev = 0; khs_prev = 0; bv_prev = 0; bhs_prev = 0;
        end else begin
            if (key_rsp_valid && (!kv_prev || khs_prev)) kfirst = cyc;
            if (key_rsp_valid && kv_prev && !khs_prev)
                chk("key_rsp_stable", 128'(key_rsp_data), 128'(kdata_prev));
            khs = key_rsp_valid && key_rsp_ready;
            if (khs) begin
                if (key_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL key_unexpected_rsp: got %h expected none", key_rsp_data);
                end else begin
                    e = key_q.pop_front();
                    chk("key_data", 128'(key_rsp_data), e.data);
                    chk("key_latency", 128'(kfirst - e.acc), 128'(e.lat));
                end
            end

            if (blk_rsp_valid && (!bv_prev || bhs_prev)) bfirst = cyc;
            bhs = blk_rsp_valid && blk_rsp_ready;
            if (bhs) begin
                if (blk_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL blk_unexpected_rsp: got %h expected none", blk_rsp_data);
                end else begin
                    e = blk_q.pop_front();
                    chk("blk_data", blk_rsp_data, e.data);
                    chk("blk_latency", 128'(bfirst - e.acc), 128'(e.lat));
                end
            end

            kv_prev = key_rsp_valid; khs_prev = khs; kdata_prev = key_rsp_data;
            bv_prev = blk_rsp_valid; bhs_prev = bhs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] BLK_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] BLK_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [31:0]  KEY_IN  = 32'hcf4f3c09;
    localparam logic [31:0]  KEY_OUT = 32'h8a84eb01;

    initial begin
        int           t;
        logic [127:0] d;

        rst_n = 1'b0;
        blk_req_valid = 0; blk_req_data = '0; blk_rsp_ready = 1;
        key_req_valid = 0; key_req_data = '0; key_rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_blk_req_ready", 128'(blk_req_ready), 128'(1));
        chk("rst_key_req_ready", 128'(key_req_ready), 128'(1));
        chk("rst_blk_rsp_valid", 128'(blk_rsp_valid), 128'(0));
        chk("rst_key_rsp_valid", 128'(key_rsp_valid), 128'(0));
        chk("rst_blk_rsp_data",  blk_rsp_data,        128'(0));
        chk("rst_key_rsp_data",  128'(key_rsp_data),  128'(0));
        chk("rst_busy",          128'(busy),          128'(0));
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Key alone, then block alone.
        key_send(KEY_IN, KEY_OUT, 1, t);
        wait_idle();
        blk_send(BLK_IN, BLK_OUT, 4, t);
        wait_idle();

        // Reset in the middle of a block job.
        blk_send(128'h00112233445566778899aabbccddeeff, 128'h0, 4, t);
        @(posedge clk); @(posedge clk);
        #2;
        chk("midjob_busy", 128'(busy), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        blk_q.delete();
        chk("midrst_blk_rsp_data",  blk_rsp_data,        128'(0));
        chk("midrst_blk_rsp_valid", 128'(blk_rsp_valid), 128'(0));
        chk("midrst_blk_req_ready", 128'(blk_req_ready), 128'(1));
        chk("midrst_busy",          128'(busy),          128'(0));
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale_valid", 128'(blk_rsp_valid), 128'(0));
            chk("post_rst_blk_req_ready",  128'(blk_req_ready), 128'(1));
        end
        @(posedge clk); #1;

        // Contention: key arrives one cycle after the block and wins the first contested pass.
        fork
            begin
                int tb;
                blk_send(BLK_IN, BLK_OUT, 5, tb);
            end
            begin
                int tk;
                @(posedge clk); #1;
                key_send(KEY_IN, KEY_OUT, 1, tk);
            end
        join
        wait_idle();
`ifdef SBOX_SHARE_STATS_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(1));
`endif

        // Backpressure on key while a block job runs, then back-to-back key job.
        key_rsp_ready = 1'b0;
        key_send(KEY_IN, KEY_OUT, 1, t);
        fork
            begin
                int tb;
                blk_send(BLK_IN, BLK_OUT, 4, tb);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
            end
        join
        key_rsp_ready = 1'b1;
        key_send(32'h01538cff, 32'h7ced6416, 1, t);
        chk("key_b2b_same_edge", 128'(t), 128'(1));
        wait_idle();

        // Byte sweep: four passes over 00..ff via 64 back-to-back block jobs.
        for (int j = 0; j < 64; j++) begin
            for (int i = 0; i < 16; i++) d[127 - 8*i -: 8] = 8'((j * 16 + i) & 255);
            blk_send(d, sub_state(d), 4, t);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
